// File: rtl/factorial_seq_ctrl.sv
// factorial_seq_ctrl: iterative n! sequencer with its control FSM.
// One multiply per MULT state; the product is formed at full width so a
// result that no longer fits in RES_WIDTH bits is detected exactly and
// parks the machine in OVF with an all-ones result.
module factorial_seq_ctrl #(
    parameter int N_WIDTH   = 4,
    parameter int RES_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [N_WIDTH-1:0]   n_in,
    input  logic                 op_clear,
    output logic [2:0]           state_code,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [RES_WIDTH-1:0] result
);

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_LOAD  = 3'b001;
    localparam logic [2:0] S_CHECK = 3'b010;
    localparam logic [2:0] S_MULT  = 3'b011;
    localparam logic [2:0] S_DEC   = 3'b100;
    localparam logic [2:0] S_DONE  = 3'b101;
    localparam logic [2:0] S_OVF   = 3'b110;

    localparam int          P_WIDTH      = RES_WIDTH + N_WIDTH;
    localparam logic [N_WIDTH-1:0]   CNT_ZERO    = {N_WIDTH{1'b0}};
    localparam logic [N_WIDTH-1:0]   CNT_ONE     = {{(N_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RES_WIDTH-1:0] RES_ZERO    = {RES_WIDTH{1'b0}};
    localparam logic [RES_WIDTH-1:0] RES_ONE     = {{(RES_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RES_WIDTH-1:0] RES_ALL_ONE = {RES_WIDTH{1'b1}};
    localparam logic [N_WIDTH-1:0]   PROD_HI_ZERO = {N_WIDTH{1'b0}};

    logic [2:0]           r_state;
    logic [N_WIDTH-1:0]   r_cnt;
    logic [RES_WIDTH-1:0] r_result;

    logic [2:0]           w_next_state;
    logic [N_WIDTH-1:0]   w_next_cnt;
    logic [RES_WIDTH-1:0] w_next_result;
    logic [P_WIDTH-1:0]   w_prod;

    // Full-width product: both operands zero-extended to P_WIDTH so no bit is lost.
    assign w_prod = {{N_WIDTH{1'b0}}, r_result} * {{RES_WIDTH{1'b0}}, r_cnt};

    // Next-state, counter and result update logic for every FSM state.
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_next_result = r_result;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD: begin
                w_next_cnt    = n_in;
                w_next_result = RES_ONE;
                w_next_state  = S_CHECK;
            end
            S_CHECK: begin
                // 0! and 1! both finish here without a multiply.
                if (r_cnt <= CNT_ONE) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_MULT;
                end
            end
            S_MULT: begin
                if (w_prod[P_WIDTH-1:RES_WIDTH] != PROD_HI_ZERO) begin
                    w_next_result = RES_ALL_ONE;
                    w_next_state  = S_OVF;
                end else begin
                    w_next_result = w_prod[RES_WIDTH-1:0];
                    w_next_state  = S_DEC;
                end
            end
            S_DEC: begin
                w_next_cnt   = r_cnt - CNT_ONE;
                w_next_state = S_CHECK;
            end
            S_DONE, S_OVF: begin
                // start wins over op_clear; neither keeps the terminal state.
                if (start) begin
                    w_next_state = S_LOAD;
                end else if (op_clear) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, counter and result registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= CNT_ZERO;
            r_result <= RES_ZERO;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_result <= w_next_result;
        end
    end

    // Status flags decoded straight from the state register (no added latency).
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        overflow = 1'b0;
        case (r_state)
            S_LOAD, S_CHECK, S_MULT, S_DEC: busy     = 1'b1;
            S_DONE:                         done     = 1'b1;
            S_OVF:                          overflow = 1'b1;
            default: begin
                busy     = 1'b0;
                done     = 1'b0;
                overflow = 1'b0;
            end
        endcase
    end

    assign state_code = r_state;
    assign result     = r_result;

endmodule

// File: tb/tb_factorial_seq_ctrl.sv
// Self-checking bench for factorial_seq_ctrl: table of n!/latency vectors,
// scoreboard queue of expected completions, hand sequences for the
// terminal-state controls and reset during MULT, then random runs.
`timescale 1ns/1ps
module tb_factorial_seq_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  n_in;
    logic        op_clear;
    logic [2:0]  state_code;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] result;

    int n_checks;
    int n_err;

    typedef struct {
        logic [3:0]  n;
        logic [31:0] exp_res;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        ovf;
        int          lat;
    } exp_t;

    vec_t       vecs[14];
    exp_t       sb[$];
    logic [2:0] trace[$];

    factorial_seq_ctrl #(.N_WIDTH(4), .RES_WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .n_in       (n_in),
        .op_clear   (op_clear),
        .state_code (state_code),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference n!: 64-bit arithmetic, overflow when the value exceeds 32 bits.
    function automatic void model(input int n, output logic [31:0] r, output logic o, output int lat);
        longint unsigned p;
        p   = 64'd1;
        o   = 1'b0;
        lat = (n < 2) ? 2 : 3 * n - 1;
        for (int k = n; k >= 2; k--) begin
            p = p * longint'(k);
            if (p > 64'h0000_0000_FFFF_FFFF) begin
                o   = 1'b1;
                lat = 3 * (n - k) + 3;
                break;
            end
        end
        r = o ? 32'hFFFF_FFFF : p[31:0];
    endfunction

    // Called #1 after a rising edge; drives start for one edge and checks LOAD.
    task automatic launch(input logic [3:0] n, input logic [31:0] r, input logic o,
                          input int lat, input string name);
        exp_t e;
        e.name = name; e.res = r; e.ovf = o; e.lat = lat;
        sb.push_back(e);
        trace.delete();
        n_in  = n;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        op_clear = 1'b0;
        trace.push_back(state_code);
        check({name, "_load"}, {61'd0, state_code}, 64'd1);
    endtask

    // Waits (bounded) for done/overflow, then pops the scoreboard and compares.
    task automatic finish_op(input bit noise);
        exp_t e;
        int   c;
        bit   ended;
        bit   busy_ok;
        c = 0; ended = 1'b0; busy_ok = 1'b1;
        while (c < 100 && !ended) begin
            @(posedge clk); #1;
            c++;
            trace.push_back(state_code);
            if (state_code == 3'b111) check("no_111", {61'd0, state_code}, 64'd0);
            if (done || overflow) begin
                ended    = 1'b1;
                start    = 1'b0;
                op_clear = 1'b0;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (noise) begin
                    start    = 1'($urandom_range(0, 1));
                    op_clear = 1'($urandom_range(0, 1));
                    n_in     = 4'($urandom_range(0, 15));
                end
            end
        end
        start = 1'b0; op_clear = 1'b0;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            if (!ended) begin
                check({e.name, "_timeout"}, 64'd0, 64'd1);
            end else begin
                check({e.name, "_busy"},   {63'd0, busy_ok},   64'd1);
                check({e.name, "_result"}, {32'd0, result},    {32'd0, e.res});
                check({e.name, "_ovf"},    {63'd0, overflow},  {63'd0, e.ovf});
                check({e.name, "_done"},   {63'd0, done},      {63'd0, ~e.ovf});
                check({e.name, "_lat"},    64'(c),             64'(e.lat));
            end
        end
    endtask

    task automatic clear_to_idle(input string name);
        op_clear = 1'b1;
        @(posedge clk); #1;
        op_clear = 1'b0;
        check({name, "_idle"}, {61'd0, state_code}, 64'd0);
    endtask

    initial begin
        logic [31:0] facts[14];
        logic [31:0] r;
        logic        o;
        int          lat;
        logic [3:0]  rn;
        bit          saw_mult;
        bit          saw_done;
        int          w;

        n_checks = 0; n_err = 0;
        facts = '{32'd1, 32'd1, 32'd2, 32'd6, 32'd24, 32'd120, 32'd720, 32'd5040,
                  32'd40320, 32'd362880, 32'd3628800, 32'd39916800, 32'd479001600,
                  32'hFFFF_FFFF};
        for (int i = 0; i < 14; i++) begin
            vecs[i].n       = 4'(i);
            vecs[i].exp_res = facts[i];
            vecs[i].exp_ovf = (i == 13);
            vecs[i].exp_lat = (i == 13) ? 36 : ((i < 2) ? 2 : 3 * i - 1);
        end

        // T1: reset values
        reset_n = 1'b0; start = 1'b0; n_in = 4'd0; op_clear = 1'b0;
        #1;
        check("rst_state", {61'd0, state_code}, 64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_flags", {61'd0, busy, done, overflow}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_stay", {61'd0, state_code}, 64'd0);

        // T2: n=5 with full state trace
        launch(4'd5, 32'd120, 1'b0, 14, "t2_n5");
        finish_op(1'b0);
        begin
            logic [2:0] exp_tr[$];
            exp_tr.push_back(3'd1); exp_tr.push_back(3'd2);
            for (int i = 0; i < 4; i++) begin
                exp_tr.push_back(3'd3); exp_tr.push_back(3'd4); exp_tr.push_back(3'd2);
            end
            exp_tr.push_back(3'd5);
            check("t2_trace_len", 64'(trace.size()), 64'(exp_tr.size()));
            for (int i = 0; i < exp_tr.size() && i < trace.size(); i++)
                if (trace[i] !== exp_tr[i]) check($sformatf("t2_trace_%0d", i), {61'd0, trace[i]}, {61'd0, exp_tr[i]});
        end

        // T5: DONE holds, start+op_clear restarts, op_clear alone returns to IDLE
        repeat (3) @(posedge clk); #1;
        check("done_hold_state", {61'd0, state_code}, 64'd5);
        check("done_hold_result", {32'd0, result}, 64'd120);
        op_clear = 1'b1;
        launch(4'd3, 32'd6, 1'b0, 8, "t5_start_clr");
        finish_op(1'b0);
        clear_to_idle("t5_clr");
        check("idle_result_hold", {32'd0, result}, 64'd6);
        launch(4'd5, 32'd120, 1'b0, 14, "t5_noise");
        finish_op(1'b1);

        // Table: n = 0..13 (T3, T4 included)
        for (int i = 0; i < 14; i++) begin
            if (i % 2 == 0) clear_to_idle($sformatf("tbl%0d", i));
            launch(vecs[i].n, vecs[i].exp_res, vecs[i].exp_ovf, vecs[i].exp_lat, $sformatf("tbl_n%0d", i));
            finish_op(1'b0);
            if (i < 2) begin
                saw_mult = 1'b0;
                foreach (trace[k]) if (trace[k] == 3'd3) saw_mult = 1'b1;
                check($sformatf("t3_nomult_n%0d", i), {63'd0, saw_mult}, 64'd0);
            end
            if (i == 13) check("t4_ovf_code", {61'd0, state_code}, 64'd6);
        end
        clear_to_idle("ovf_clr");

        // T6: reset during MULT of n=9
        n_in = 4'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (state_code != 3'd3 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check("t6_reach_mult", {61'd0, state_code}, 64'd3);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_state", {61'd0, state_code}, 64'd0);
        check("t6_rst_result", {32'd0, result}, 64'd0);
        check("t6_rst_flags", {61'd0, busy, done, overflow}, 64'd0);
        @(negedge clk); reset_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || state_code != 3'd0) saw_done = 1'b1;
        end
        check("t6_no_done", {63'd0, saw_done}, 64'd0);

        // Random runs with busy-time noise, mixed restart / clear
        for (int i = 0; i < 1000; i++) begin
            rn = 4'($urandom_range(0, 15));
            model(int'(rn), r, o, lat);
            if ($urandom_range(0, 1) == 1) clear_to_idle("rnd");
            launch(rn, r, o, lat, $sformatf("rnd%0d_n%0d", i, rn));
            finish_op(($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
